event_encoder83: RTL and testbench
==================================

EVENT_ENCODER83 -- requirements
Module: event_encoder83

Interface
REQ-001 Parameter: RR_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round-robin priority.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  capture enable; low = new rising edges are ignored.
REQ-005 Port: req  input  8  event request lines, one bit per source.
REQ-006 Port: code_valid  output  1  code holds a pending event index.
REQ-007 Port: code  output  3  binary index of the presented event.
REQ-008 Port: code_ready  input  1  consumer accept; a handshake occurs on a cycle with code_valid=1 and code_ready=1.
REQ-009 Port: pend  output  8  registered pending-event vector.
REQ-010 Port: pend_cnt  output  4  registered popcount of pend, range 0..8.
REQ-011 Port: ovf  output  1  one-cycle pulse when an event merges into an already-pending bit.

Function
REQ-012 Edge detect SHALL use a registered req_q: rise = req & ~req_q & {8{en}}. req_q updates every cycle regardless of en.
REQ-013 Terms: clr = one-hot(code) on a handshake cycle, else 0. pend_next = (pend & ~clr) | rise. pend <= pend_next every cycle.
REQ-014 Rise on the bit being cleared in the same cycle SHALL leave the bit pending. No ovf is raised for that bit.
REQ-015 ovf SHALL pulse high for exactly the cycle after any bit has rise=1 and (pend & ~clr)=1 in the same cycle. The event SHALL merge and not be counted twice.
REQ-016 FSM states:
- IDLE: code_valid=0.
- PRESENT: code_valid=1, code stable.
REQ-017 IDLE -> PRESENT when pend_next != 0. code <= select(pend_next) on that edge, so code_valid rises one cycle after the req edge is sampled.
REQ-018 In PRESENT without a handshake, code and code_valid SHALL hold unchanged, whatever new rises arrive.
REQ-019 In PRESENT with a handshake:
- if pend_next != 0: stay in PRESENT and load code <= select(pend_next), giving back-to-back throughput of 1 code per cycle;
- otherwise go to IDLE.
REQ-020 The presented bit SHALL remain set in pend until its handshake.
REQ-021 Selection when RR_MODE=0: lowest set index of pend_next.
REQ-022 Selection when RR_MODE=1: first set index searching upward from ptr, modulo 8. ptr is a 3-bit register, reset to 0. On every handshake, ptr <= code+1 (wraps 7 -> 0).
REQ-023 pend_cnt SHALL equal popcount(pend), registered with pend.
REQ-024 en low SHALL NOT clear pend or abort a presented code. Handshakes continue to drain pend.

Reset
REQ-025 While rst_n=0, immediately and asynchronously:
- state = IDLE;
- code_valid = 0, code = 0;
- pend = 0, pend_cnt = 0, ovf = 0;
- req_q = 0, ptr = 0.
REQ-026 Because req_q resets to 0, a req bit already high at reset release SHALL count as a rise on the first clock edge after release (when en=1).
REQ-027 Reset asserted mid-handshake SHALL discard all pending events. No code is presented until a new rise occurs.

Verification
REQ-028 Single event: req=0x04 from 0x00, en=1, code_ready=1 -> code_valid=1 with code=2 one cycle later. After the handshake: pend=0x00, state IDLE, pend_cnt=0.
REQ-029 Fixed-priority burst, RR_MODE=0: req 0x00 -> 0xA2 in one cycle, code_ready=1 -> codes 1, 5, 7 on consecutive cycles. pend_cnt goes 3, 2, 1, 0.
REQ-030 Round-robin, RR_MODE=1: grant code 5, then raise bits 1 and 6 together -> next code=6, then code=1.
REQ-031 Backpressure and overflow: code_ready=0 while code=3 is presented. Toggle req[3] 0 -> 1 again -> ovf pulses for 1 cycle, pend=0x08, code stays 3.
REQ-032 Simultaneous clear and rise: a handshake on code=0 while req[0] rises in the same cycle -> ovf=0, pend[0] remains 1, code_valid stays 1 with code=0.
REQ-033 Reset and enable:
- req=0xFF held through rst_n release -> after the first edge, pend=0xFF and pend_cnt=8;
- with en=0, new rising edges -> pend unchanged.

Source files
------------

// File: rtl/event_encoder83.sv
// event_encoder83: captures rising edges on eight request lines into a
// pending vector and presents them one at a time as a binary index with a
// valid/ready handshake. Priority is either fixed (lowest index first) or
// round-robin, chosen by RR_MODE.
module event_encoder83 #(
  parameter int unsigned RR_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] req,
  output logic       code_valid,
  output logic [2:0] code,
  input  logic       code_ready,
  output logic [7:0] pend,
  output logic [3:0] pend_cnt,
  output logic       ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pend_q, pend_d;
  logic [3:0] pend_cnt_q, pend_cnt_d;
  logic       ovf_q, ovf_d;
  logic [2:0] code_q, code_d;
  logic [2:0] ptr_q, ptr_d;

  logic [7:0] rise_s;
  logic [7:0] clr_s;
  logic [7:0] kept_s;
  logic       hs_s;

  // Number of set bits in an 8-bit vector.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Pick the next index to present: lowest set bit in fixed mode, or the
  // first set bit at or above the pointer (wrapping) in round-robin mode.
  function automatic logic [2:0] select8(input logic [7:0] v, input logic [2:0] start);
    logic [2:0] idx;
    logic [2:0] pick;
    logic       found;
    pick  = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (RR_MODE == 0) begin
        idx = 3'(i);
      end else begin
        idx = start + 3'(i);
      end
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        pick  = pick;
      end
    end
    return pick;
  endfunction

  // State register: all flops, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 8'h00;
      pend_q     <= 8'h00;
      pend_cnt_q <= 4'd0;
      ovf_q      <= 1'b0;
      code_q     <= 3'd0;
      ptr_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
      ovf_q      <= ovf_d;
      code_q     <= code_d;
      ptr_q      <= ptr_d;
    end
  end

  // Next-state: edge capture, pending merge/clear, and presentation control.
  always_comb begin
    rise_s     = req & ~req_q & {8{en}};
    hs_s       = (state_q == PRESENT) && code_ready;
    clr_s      = hs_s ? (8'b0000_0001 << code_q) : 8'h00;
    kept_s     = pend_q & ~clr_s;
    req_d      = req;
    pend_d     = kept_s | rise_s;
    pend_cnt_d = popcount8(pend_d);
    // A rise on a bit still pending merges; a rise on the bit being cleared
    // this cycle simply re-arms it and is not an overflow.
    ovf_d      = |(rise_s & kept_s);
    // The pointer moves on the handshake edge, and the code loaded on that
    // same edge already uses the advanced pointer.
    ptr_d      = hs_s ? (code_q + 3'd1) : ptr_q;
    state_d    = state_q;
    code_d     = code_q;
    case (state_q)
      IDLE: begin
        if (pend_d != 8'h00) begin
          state_d = PRESENT;
          code_d  = select8(pend_d, ptr_d);
        end else begin
          state_d = IDLE;
        end
      end
      PRESENT: begin
        if (hs_s) begin
          if (pend_d != 8'h00) begin
            state_d = PRESENT;
            code_d  = select8(pend_d, ptr_d);
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: driven straight from registers.
  always_comb begin
    code_valid = (state_q == PRESENT);
    code       = code_q;
    pend       = pend_q;
    pend_cnt   = pend_cnt_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_event_encoder83.sv
// Directed bench for event_encoder83: one fixed-priority and one round-robin
// instance share all inputs; each scenario checks the relevant instance.
`timescale 1ns/1ps
module tb_event_encoder83;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic       code_ready;

  logic       v0, v1;
  logic [2:0] c0, c1;
  logic [7:0] p0, p1;
  logic [3:0] n0, n1;
  logic       o0, o1;

  int n_checks = 0;
  int n_fail   = 0;

  event_encoder83 #(.RR_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .code_valid(v0), .code(c0), .code_ready(code_ready),
    .pend(p0), .pend_cnt(n0), .ovf(o0)
  );

  event_encoder83 #(.RR_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .code_valid(v1), .code(c1), .code_ready(code_ready),
    .pend(p1), .pend_cnt(n1), .ovf(o1)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = 8'h00; code_ready = 1'b0; en = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 8'h00; en = 1'b1; code_ready = 1'b0;
    #3;
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", v0); end
    n_checks++; if (c0 !== 3'd0) begin n_fail++; $display("FAIL reset_code got %0d exp 0", c0); end
    n_checks++; if (p0 !== 8'h00) begin n_fail++; $display("FAIL reset_pend got %h exp 00", p0); end
    n_checks++; if (n0 !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d exp 0", n0); end
    n_checks++; if (o0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b exp 0", o0); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h04; code_ready = 1'b1;
    tick();
    n_checks++; if (v0 !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0b exp 1", v0); end
    n_checks++; if (c0 !== 3'd2) begin n_fail++; $display("FAIL single_code got %0d exp 2", c0); end
    n_checks++; if (p0 !== 8'h04) begin n_fail++; $display("FAIL single_pend got %h exp 04", p0); end
    n_checks++; if (n0 !== 4'd1) begin n_fail++; $display("FAIL single_cnt got %0d exp 1", n0); end
    tick();
    n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL single_idle got %0b exp 0", v0); end
    n_checks++; if (p0 !== 8'h00) begin n_fail++; $display("FAIL single_drain got %h exp 00", p0); end
    n_checks++; if (n0 !== 4'd0) begin n_fail++; $display("FAIL single_cnt0 got %0d exp 0", n0); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_fixed_burst();
    logic [2:0] exp_code [3];
    logic [3:0] exp_cnt  [3];
    exp_code[0] = 3'd1; exp_code[1] = 3'd5; exp_code[2] = 3'd7;
    exp_cnt[0]  = 4'd3; exp_cnt[1]  = 4'd2; exp_cnt[2]  = 4'd1;
    do_reset();
    req = 8'hA2; code_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (v0 !== 1'b1 || c0 !== exp_code[i]) begin n_fail++; $display("FAIL burst_code[%0d] got v=%0b c=%0d exp v=1 c=%0d", i, v0, c0, exp_code[i]); end
      n_checks++; if (n0 !== exp_cnt[i]) begin n_fail++; $display("FAIL burst_cnt[%0d] got %0d exp %0d", i, n0, exp_cnt[i]); end
    end
    tick();
    n_checks++; if (n0 !== 4'd0 || v0 !== 1'b0) begin n_fail++; $display("FAIL burst_end got cnt=%0d v=%0b exp cnt=0 v=0", n0, v0); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 8'h20; code_ready = 1'b1;
    tick();
    n_checks++; if (v1 !== 1'b1 || c1 !== 3'd5) begin n_fail++; $display("FAIL rr_first got v=%0b c=%0d exp v=1 c=5", v1, c1); end
    tick();
    n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL rr_idle got %0b exp 0", v1); end
    req = 8'h62;
    tick();
    n_checks++; if (c1 !== 3'd6 || p1 !== 8'h42) begin n_fail++; $display("FAIL rr_code6 got c=%0d p=%h exp c=6 p=42", c1, p1); end
    n_checks++; if (c0 !== 3'd1) begin n_fail++; $display("FAIL fixed_contrast got %0d exp 1", c0); end
    tick();
    n_checks++; if (v1 !== 1'b1 || c1 !== 3'd1) begin n_fail++; $display("FAIL rr_code1 got v=%0b c=%0d exp v=1 c=1", v1, c1); end
    tick();
    n_checks++; if (v1 !== 1'b0 || p1 !== 8'h00) begin n_fail++; $display("FAIL rr_end got v=%0b p=%h exp v=0 p=00", v1, p1); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_backpressure_ovf();
    do_reset();
    req = 8'h08; code_ready = 1'b0;
    tick();
    n_checks++; if (v0 !== 1'b1 || c0 !== 3'd3) begin n_fail++; $display("FAIL bp_present got v=%0b c=%0d exp v=1 c=3", v0, c0); end
    req = 8'h00;
    tick();
    n_checks++; if (o0 !== 1'b0) begin n_fail++; $display("FAIL bp_no_ovf got %0b exp 0", o0); end
    req = 8'h08;
    tick();
    n_checks++; if (o0 !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %0b exp 1", o0); end
    n_checks++; if (p0 !== 8'h08 || n0 !== 4'd1) begin n_fail++; $display("FAIL ovf_merge got p=%h n=%0d exp p=08 n=1", p0, n0); end
    n_checks++; if (c0 !== 3'd3) begin n_fail++; $display("FAIL ovf_hold got %0d exp 3", c0); end
    req = 8'h09;
    tick();
    n_checks++; if (o0 !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %0b exp 0", o0); end
    n_checks++; if (c0 !== 3'd3 || v0 !== 1'b1 || p0 !== 8'h09) begin n_fail++; $display("FAIL bp_hold got c=%0d v=%0b p=%h exp c=3 v=1 p=09", c0, v0, p0); end
    code_ready = 1'b1;
    tick();
    n_checks++; if (c0 !== 3'd0 || p0 !== 8'h01) begin n_fail++; $display("FAIL bp_next got c=%0d p=%h exp c=0 p=01", c0, p0); end
    code_ready = 1'b0; req = 8'h08;
    tick();
    req = 8'h09; code_ready = 1'b1;
    tick();
    n_checks++; if (o0 !== 1'b0) begin n_fail++; $display("FAIL clr_rise_ovf got %0b exp 0", o0); end
    n_checks++; if (p0 !== 8'h01 || v0 !== 1'b1 || c0 !== 3'd0) begin n_fail++; $display("FAIL clr_rise got p=%h v=%0b c=%0d exp p=01 v=1 c=0", p0, v0, c0); end
    tick();
    n_checks++; if (p0 !== 8'h00 || v0 !== 1'b0) begin n_fail++; $display("FAIL clr_rise_drain got p=%h v=%0b exp p=00 v=0", p0, v0); end
    req = 8'h00;
    tick();
  endtask

  task automatic test_reset_en();
    rst_n = 1'b0; req = 8'hFF; en = 1'b1; code_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (p0 !== 8'hFF || n0 !== 4'd8) begin n_fail++; $display("FAIL release_pend got p=%h n=%0d exp p=FF n=8", p0, n0); end
    n_checks++; if (v0 !== 1'b1 || c0 !== 3'd0) begin n_fail++; $display("FAIL release_code got v=%0b c=%0d exp v=1 c=0", v0, c0); end
    en = 1'b0; req = 8'h00;
    tick();
    req = 8'hFF;
    tick();
    n_checks++; if (p0 !== 8'hFF || o0 !== 1'b0) begin n_fail++; $display("FAIL en_low got p=%h ovf=%0b exp p=FF ovf=0", p0, o0); end
    code_ready = 1'b1;
    tick();
    n_checks++; if (p0 !== 8'hFE || n0 !== 4'd7 || c0 !== 3'd1) begin n_fail++; $display("FAIL en_low_drain got p=%h n=%0d c=%0d exp p=FE n=7 c=1", p0, n0, c0); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (v0 !== 1'b0 || p0 !== 8'h00 || n0 !== 4'd0) begin n_fail++; $display("FAIL async_reset got v=%0b p=%h n=%0d exp v=0 p=00 n=0", v0, p0, n0); end
    req = 8'h00; en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    n_checks++; if (v0 !== 1'b0 || p0 !== 8'h00) begin n_fail++; $display("FAIL post_reset got v=%0b p=%h exp v=0 p=00", v0, p0); end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; req = 8'h00; code_ready = 1'b0;
    test_reset();
    test_single();
    test_fixed_burst();
    test_round_robin();
    test_backpressure_ovf();
    test_reset_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
